// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Lane width, latency counter width and the out-of-range read value.
package data_mem_resp_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } stateT;

  localparam int LANE_W = 8;
  localparam int CNT_W = 3;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Overlay the enabled byte lanes of newW onto oldW.
  function automatic logic [31:0] laneMerge(
    input logic [31:0] oldW,
    input logic [31:0] newW,
    input logic [3:0]  we
  );
    logic [31:0] r;
    r = oldW;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        r[i*LANE_W +: LANE_W] = newW[i*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_we_ram.sv
// Word RAM with per-byte write enables and a registered read port.
// A read and write to the same word in one cycle returns the new bytes.
module byte_we_ram
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] merged;

  assign merged = laneMerge(mem[addr], wdata, we);

  // Byte-lane writes plus write-first registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    if (re) begin
      rdata <= merged;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: address decode, latency FSM, stall, error flag.
// Optional out-of-range detection enabled by DATA_MEM_RESP_ERR_EN.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        addr_err
);

  stateT             state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pendIdx;
  logic              pendErr;
  logic              rdValid;
  logic              rdErr;

  logic [31:0]       offset;
  logic [ADDR_W-1:0] wordIdx;
  logic              outOfRange;
  logic              isRead;
  logic              accept;
  logic              finishing;
  logic [ADDR_W-1:0] ramAddr;
  logic [3:0]        ramWe;
  logic              ramRe;
  logic [31:0]       ramQ;

  assign offset  = mem_addr - BASE_ADDR;
  assign wordIdx = ADDR_W'(offset >> 2);

`ifdef DATA_MEM_RESP_ERR_EN
  assign outOfRange = {1'b0, offset} >= (33'd4 << ADDR_W);
`else
  assign outOfRange = 1'b0;
`endif

  // Reset holds off any RAM access on the reset edge.
  assign isRead    = mem_wen == 4'b0000;
  assign accept    = rst && mem_en && !mem_stall;
  assign finishing = (state == WAIT) && (cnt == CNT_W'(1));

  // The request is stable during a stall, so the RAM is read at the
  // completing edge instead of holding a second data register.
  assign ramAddr = (state == WAIT) ? pendIdx : wordIdx;
  assign ramWe   = (accept && !outOfRange) ? mem_wen : 4'b0000;
  assign ramRe   = (LATENCY == 1)
                 ? (accept && isRead && !outOfRange)
                 : (finishing && !pendErr);

  byte_we_ram #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk  (clk),
    .addr (ramAddr),
    .we   (ramWe),
    .re   (ramRe),
    .wdata(mem_wdata),
    .rdata(ramQ)
  );

  // Read-latency FSM: single-cycle reads complete at acceptance,
  // longer ones park in WAIT with the stall raised until the count ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_stall <= 1'b0;
      pendIdx   <= '0;
      pendErr   <= 1'b0;
      rdValid   <= 1'b0;
      rdErr     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && isRead) begin
            if (LATENCY == 1) begin
              rdValid <= 1'b1;
              rdErr   <= outOfRange;
            end else begin
              state     <= WAIT;
              cnt       <= CNT_W'(LATENCY - 1);
              mem_stall <= 1'b1;
              pendIdx   <= wordIdx;
              pendErr   <= outOfRange;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (finishing) begin
            state     <= IDLE;
            mem_stall <= 1'b0;
            rdValid   <= 1'b1;
            rdErr     <= pendErr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rdata = !rdValid ? 32'h0
                   : (rdErr ? ERR_RDATA : ramQ);

`ifdef DATA_MEM_RESP_ERR_EN
  logic addrErrQ;

  // One-cycle pulse after an out-of-range request is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addrErrQ <= 1'b0;
    end else begin
      addrErrQ <= accept && outOfRange;
    end
  end

  assign addr_err = addrErrQ;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at latencies 1, 3 and 4.
// Directed table, corner sequences, then random ops against a word model.
module tb_data_mem_responder;

`ifdef DATA_MEM_RESP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] addr3;
  logic [31:0] wdata;
  logic [31:0] rd [3];
  logic [2:0]  st;
  logic [2:0]  er;

  int nPass = 0;
  int nTot = 0;
  int lat [3];
  logic [31:0] prevRd [3];
  logic [31:0] mdl [16];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] exp;
  } vecT;

  vecT tbl [$];

  always #5 clk = ~clk;

  assign addr3 = addr + 32'h0000_2000;

  data_mem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .rst(rst), .mem_en(en), .mem_wen(wen),
    .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdata(rd[0]), .mem_stall(st[0]), .addr_err(er[0])
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(3), .BASE_ADDR(32'h2000)) u3 (
    .clk(clk), .rst(rst), .mem_en(en), .mem_wen(wen),
    .mem_addr(addr3), .mem_wdata(wdata),
    .mem_rdata(rd[1]), .mem_stall(st[1]), .addr_err(er[1])
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(4), .BASE_ADDR(32'h0)) u4 (
    .clk(clk), .rst(rst), .mem_en(en), .mem_wen(wen),
    .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdata(rd[2]), .mem_stall(st[2]), .addr_err(er[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nTot++;
    if (act === exp) nPass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  // One request held for a single edge, then observed until all settle.
  task automatic req(input bit wr, input logic [31:0] a,
                     input logic [3:0] w, input logic [31:0] d,
                     input logic [31:0] expRd, input bit expErr);
    int stl [3];
    @(negedge clk);
    en = 1'b1;
    wen = wr ? w : 4'b0000;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    wen = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      stl[i] = int'(st[i]);
      chk($sformatf("errPulse%0d a=%h", i, a), 32'(er[i]), 32'(expErr));
    end
    if (!wr) begin
      chk($sformatf("lat1Rd a=%h", a), rd[0], expRd);
      chk($sformatf("lat3Hold a=%h", a), rd[1], prevRd[1]);
      chk($sformatf("lat4Hold a=%h", a), rd[2], prevRd[2]);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) stl[i] += int'(st[i]);
      if (k == 0) chk($sformatf("errWidth a=%h", a), 32'(er), 32'(0));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stallCyc%0d a=%h", i, a), 32'(stl[i]),
          32'(wr ? 0 : lat[i] - 1));
      if (wr) begin
        chk($sformatf("rdKeep%0d a=%h", i, a), rd[i], prevRd[i]);
      end else begin
        chk($sformatf("rdData%0d a=%h", i, a), rd[i], expRd);
        prevRd[i] = expRd;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
    logic [3:0]  w;
    bit          wr;
    bit          hi;
    int          idx;

    lat[0] = 1; lat[1] = 3; lat[2] = 4;
    rst = 1'b0; en = 1'b1; wen = 4'hF; addr = 32'h10; wdata = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstRd%0d", i), rd[i], 32'h0);
      chk($sformatf("rstStall%0d", i), 32'(st[i]), 32'h0);
      chk($sformatf("rstErr%0d", i), 32'(er[i]), 32'h0);
      prevRd[i] = 32'h0;
    end
    en = 1'b0; wen = 4'h0;
    @(negedge clk);
    rst = 1'b1;

    tbl.push_back('{1, 32'h10,   4'hF, 32'h0000_0000, 32'h0});
    tbl.push_back('{0, 32'h10,   4'h0, 32'h0,         32'h0});
    tbl.push_back('{1, 32'h20,   4'hF, 32'h1122_3344, 32'h0});
    tbl.push_back('{1, 32'h20,   4'h2, 32'h0000_AB00, 32'h0});
    tbl.push_back('{0, 32'h20,   4'h0, 32'h0,         32'h1122_AB44});
    tbl.push_back('{1, 32'h40,   4'hF, 32'hCAFE_F00D, 32'h0});
    tbl.push_back('{0, 32'h40,   4'h0, 32'h0,         32'hCAFE_F00D});
    tbl.push_back('{1, 32'h8,    4'hF, 32'h0000_0055, 32'h0});
    tbl.push_back('{0, 32'h8,    4'h0, 32'h0,         32'h0000_0055});
    tbl.push_back('{1, 32'hC,    4'hF, 32'h1234_5678, 32'h0});
    tbl.push_back('{0, 32'hA,    4'h0, 32'h0,         32'h0000_0055});
    tbl.push_back('{1, 32'h20,   4'h9, 32'h9988_7766, 32'h0});
    tbl.push_back('{0, 32'h20,   4'h0, 32'h0,         32'h9922_AB66});
    tbl.push_back('{1, 32'h0,    4'hF, 32'h0000_0000, 32'h0});
    tbl.push_back('{1, 32'h1000, 4'hF, 32'hA5A5_A5A5, 32'h0});
    tbl.push_back('{0, 32'h0,    4'h0, 32'h0,
                    ERR_ON ? 32'h0 : 32'hA5A5_A5A5});
    tbl.push_back('{0, 32'h1000, 4'h0, 32'h0,
                    ERR_ON ? 32'hDEAD_BEEF : 32'hA5A5_A5A5});

    foreach (tbl[j]) begin
      req(tbl[j].wr, tbl[j].a, tbl[j].w, tbl[j].d, tbl[j].exp,
          ERR_ON && (tbl[j].a >= 32'h1000));
    end

    // Second request held through the latency-3 stall.
    @(negedge clk);
    en = 1'b1; wen = 4'h0; addr = 32'h40;
    @(posedge clk); #1;
    chk("heldE0Stall", 32'(st[1]), 32'h1);
    addr = 32'h20;
    @(posedge clk); #1;
    chk("heldE1Stall", 32'(st[1]), 32'h1);
    chk("heldE1Rd", rd[1], prevRd[1]);
    @(posedge clk); #1;
    chk("heldE2Stall", 32'(st[1]), 32'h0);
    chk("heldE2Rd", rd[1], 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("heldE3Stall", 32'(st[1]), 32'h1);
    chk("heldE3Rd", rd[1], 32'hCAFE_F00D);
    en = 1'b0;
    @(posedge clk); #1;
    chk("heldE4Stall", 32'(st[1]), 32'h1);
    @(posedge clk); #1;
    chk("heldE5Stall", 32'(st[1]), 32'h0);
    chk("heldE5Rd", rd[1], 32'h9922_AB66);
    repeat (3) @(posedge clk);
    #1;
    chk("heldLat1Rd", rd[0], 32'h9922_AB66);
    chk("heldLat4Rd", rd[2], 32'hCAFE_F00D);
    chk("heldLat4Stall", 32'(st[2]), 32'h0);
    prevRd[0] = rd[0] === 32'h9922_AB66 ? 32'h9922_AB66 : 32'hX;
    prevRd[0] = 32'h9922_AB66;
    prevRd[1] = 32'h9922_AB66;
    prevRd[2] = 32'hCAFE_F00D;

    // Reset during the second stall cycle of the latency-4 read.
    @(negedge clk);
    en = 1'b1; wen = 4'h0; addr = 32'h40;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("abortPreStall", 32'(st[2]), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abortStall%0d", i), 32'(st[i]), 32'h0);
      chk($sformatf("abortRd%0d", i), rd[i], 32'h0);
      prevRd[i] = 32'h0;
    end
    req(1'b0, 32'h40, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Random traffic against a 16-word model; hi selects the alias window.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      mdl[i] = d;
      req(1'b1, 32'(i * 4), 4'hF, d, 32'h0, 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 15);
      hi = $urandom_range(0, 3) == 0;
      a = (hi ? 32'h1000 : 32'h0) + 32'(idx * 4) + 32'($urandom_range(0, 3));
      wr = $urandom_range(0, 9) < 6;
      w = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      d = $urandom;
      if (wr) begin
        if (!(ERR_ON && hi)) begin
          for (int b = 0; b < 4; b++) begin
            if (w[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
          end
        end
        e = 32'h0;
      end else begin
        e = (ERR_ON && hi) ? 32'hDEAD_BEEF : mdl[idx];
      end
      req(wr, a, w, d, e, ERR_ON && hi);
    end

    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port. The core drives mem_en, mem_wen[3:0], mem_addr and mem_wdata; this block returns mem_rdata.
- Holds a word-organised RAM with per-byte write enables and a synchronous read.
- Read latency is programmable. A stall output lets the pipeline freeze while a multi-cycle read is pending.
- Sits between the core's M stage and the SoC; used as the simulation/FPGA data memory.

Parameters:
- ADDR_W, 10: word-address bits. Depth is 2^ADDR_W words (4 KB at default).
- LATENCY, 1: cycles from request acceptance to valid mem_rdata. Legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address that maps to word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Synchronous, active-low.
- mem_en  in  1  request strobe.
- mem_wen  in  4  byte write enables. Any bit set means write; 4'b0000 with mem_en means read.
- mem_addr  in  32  byte address. Bits [1:0] are ignored.
- mem_wdata  in  32  write data, already lane-aligned by the core.
- mem_rdata  out  32  read data.
- mem_stall  out  1  high while a read is pending. The core must hold its request stable while this is high.
- addr_err  out  1  out-of-range pulse (see Optional Feature).

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, mem_stall=0, mem_rdata=0, addr_err=0, latency counter=0.
  - RAM contents are not cleared.
- Word index: (mem_addr - BASE_ADDR) >> 2, truncated to ADDR_W bits, so addresses wrap modulo the depth.
- A request is accepted on a rising edge with mem_en=1 && mem_stall=0.
- Write (mem_wen != 0):
  - Only the lanes with mem_wen[i]=1 are updated at the accepting edge: lane i is bits [8i+7:8i].
  - Never stalls.
  - mem_rdata is unchanged.
- Read, LATENCY=1:
  - mem_rdata is valid after the accepting edge, i.e. registered one cycle later.
  - mem_stall stays 0.
- Read, LATENCY=N>1:
  - At the accepting edge: state IDLE->WAIT, counter loaded with N-1, mem_stall=1 from the next cycle.
  - Counter decrements each cycle. On the edge where it reaches 0: mem_rdata is loaded, state WAIT->IDLE, mem_stall deasserts.
  - mem_stall is therefore high for exactly N-1 cycles.
- Requests arriving while mem_stall=1 are ignored.
- The data returned is the RAM content at the accepting edge; a write cannot be issued mid-read.
- mem_rdata holds its last read value until the next read completes. Writes and idle cycles do not disturb it.
- Read-after-write to the same word on back-to-back accepted requests returns the newly written bytes (no stale read).
- mem_en=0: no RAM access, no state change.
- rst asserted while in WAIT: the pending read is aborted, state returns to IDLE, mem_stall=0, mem_rdata=0.
- State machine: IDLE, WAIT. DONE is folded into the WAIT exit edge.

Optional Feature:
- Macro: DATA_MEM_RESP_ERR_EN.
- When defined, any accepted request whose (mem_addr - BASE_ADDR) >= 4*2^ADDR_W is treated as out of range:
  - addr_err pulses high for one cycle after the accepting edge.
  - A write is suppressed (RAM unchanged).
  - A read returns 32'hDEAD_BEEF with normal latency and stall timing.
- When not defined: addr_err is tied to 0 and all addresses wrap as described in Behaviour.

Decomposition:
- Package data_mem_resp_pkg holds:
  - the state enum (IDLE, WAIT);
  - the lane-width constant (8);
  - the error read value 32'hDEAD_BEEF;
  - a latency-counter width constant (3 bits).
- One natural sub-module, byte_we_ram:
  - 2^ADDR_W x 32 array with 4 byte write enables and a synchronous read port;
  - write-first on a same-address read/write.
- The top level holds the FSM, latency counter, address decode and the error logic.

Test Plan:
- Reset then a read of 0x0000_0010 at LATENCY=1 -> mem_rdata=0 (after an init write of 0) one cycle later, mem_stall never asserted.
- Write 0x1122_3344 to 0x20 with wen=4'b1111, then wen=4'b0010 with wdata 0x0000_AB00 -> a read of 0x20 returns 0x1122_AB44.
- LATENCY=3: read 0x40 holding 0xCAFE_F00D -> mem_stall high for exactly 2 cycles, mem_rdata=0xCAFE_F00D on the edge that drops the stall; a second request held during the stall is accepted only afterwards.
- ADDR_W=10: write 0xA5A5_A5A5 to 0x1000 -> a read of 0x0000 returns 0xA5A5_A5A5 (wrap, macro off); with DATA_MEM_RESP_ERR_EN defined -> addr_err pulse, RAM unchanged, read of 0x1000 returns 0xDEAD_BEEF.
- LATENCY=4: rst driven low during the 2nd stall cycle -> next cycle mem_stall=0 and mem_rdata=0; a subsequent read completes normally.
- Write 0x55 to 0x8 immediately followed by a read of 0x8 -> 0x0000_0055; mem_rdata unchanged across intervening writes and idle cycles.
